button_press: RTL

Debounce and edge-qualification stage for one player button in the Tug of War game. Sits directly downstream of the two-flop button synchronizer. Takes the synchronized level and emits exactly one single-cycle `press` pulse per debounced press, plus a debounced `held` level. The game/score logic consumes `press` as its only notion of "one pull".

---
 rtl/button_press.sv | 68 ++++++
 1 files changed

// File: rtl/button_press.sv
// button_press: debounces a synchronized button into a one-cycle press pulse and a held level.
// Define BUTTON_PRESS_COUNT_EN to build the 8-bit press_count register; otherwise it reads 0.
module button_press #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       press,
    output logic       held,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic done, press_nx, held_nx;
    assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            press <= press_nx;
            held  <= held_nx;
        end
    end
    // Any opposite sample in a wait state falls back to the stable state, so cnt never accumulates across glitches.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (button) begin
                state_nx = PRESS_WAIT;
                cnt_nx   = '0;
            end
            PRESS_WAIT: if (!button) state_nx = IDLE;
                else if (done) state_nx = HELD;
                else cnt_nx = cnt + 1'b1;
            HELD: if (!button) begin
                state_nx = RELEASE_WAIT;
                cnt_nx   = '0;
            end
            RELEASE_WAIT: if (button) state_nx = HELD;
                else if (done) state_nx = IDLE;
                else cnt_nx = cnt + 1'b1;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        press_nx = state == PRESS_WAIT && button && done;
        held_nx  = state_nx == HELD || state_nx == RELEASE_WAIT;
    end
`ifdef BUTTON_PRESS_COUNT_EN
    logic [7:0] count_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= 8'd0;
        else if (press_nx) count_q <= count_q + 8'd1;
    end
    assign press_count = count_q;
`else
    assign press_count = 8'd0;
`endif
endmodule
